// File: rtl/dmem_dump_pkg.sv
// rtl/dmem_dump_pkg.sv - shared types and helpers for the data-memory dump controller
//
// Purpose:
//   Holds the dump sequencer state type and a helper that turns a word-address
//   width into a memory depth, so the top and any users agree on both.
// Contents:
//   dump_state_t  IDLE / READ / SEND / DONE
//   depth()       number of words addressed by an addr_w-bit word address

package dmem_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dmem_dump_ctrl_rise_detect.sv
// rtl/dmem_dump_ctrl_rise_detect.sv - single-flop rising-edge detector for debug strobes
//
// Purpose:
//   Flags a cycle in which sig_i is high and was low at the previous clock edge.
//   The reset value of the history flop is a parameter: resetting it to 1 means
//   a strobe that is already high when reset releases is not seen as an edge.
// Ports:
//   clk     in   clock, history sampled on the rising edge
//   rst_n   in   asynchronous active-low reset
//   sig_i   in   strobe to watch
//   rise_o  out  combinational edge flag, valid for the edge about to occur

module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/dmem_dump_ctrl.sv
// rtl/dmem_dump_ctrl.sv - data-memory port arbiter and word-dump sequencer
//
// Purpose:
//   Normally forwards the processor's data-memory requests unchanged. A rising
//   edge on dump_req (seen while idle) stalls the processor, takes the memory
//   port, and streams every word out in ascending address order over a
//   valid/ready interface, then pulses done and releases the stall.
// Ports:
//   CLOCK_50   in   system clock
//   reset      in   asynchronous active-low reset
//   dump_req   in   dump request, rising edge starts a dump
//   cpu_addr   in   processor byte address
//   cpu_wdata  in   processor store data
//   cpu_we     in   processor store enable
//   cpu_stall  out  freezes processor PC / register writes
//   mem_addr   out  word address to data memory
//   mem_wdata  out  write data to data memory
//   mem_we     out  write enable to data memory
//   mem_rdata  in   combinational read data from data memory
//   out_valid  out  dump word available
//   out_ready  in   consumer accepts dump word
//   out_data   out  dump word
//   out_index  out  word index of out_data
//   out_last   out  marks the final word of a dump
//   busy       out  any state other than IDLE
//   done       out  one-cycle completion pulse

module dmem_dump_ctrl
    import dmem_dump_pkg::*;
#(
    parameter int N      = 64,
    parameter int ADDR_W = 6
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              dump_req,
    input  logic [N-1:0]      cpu_addr,
    input  logic [N-1:0]      cpu_wdata,
    input  logic              cpu_we,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              mem_we,
    input  logic [N-1:0]      mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int                DEPTH   = depth(ADDR_W);
    localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(DEPTH - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [N-1:0]      out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              dump_rise;
    logic              at_last;

    // Byte-offset bits and address bits above the memory are not decoded.
    logic unused_cpu_addr;
    assign unused_cpu_addr = ^{cpu_addr[N-1:ADDR_W+3], cpu_addr[2:0]};

    rise_detect #(
        .RST_VAL (1'b1)
    ) u_dump_rise (
        .clk    (CLOCK_50),
        .rst_n  (reset),
        .sig_i  (dump_req),
        .rise_o (dump_rise)
    );

    assign at_last = (idx_q == IDX_MAX);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        case (state_q)
            IDLE: begin
                // Edges seen in other states are dropped, never queued.
                if (dump_rise) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                // Memory read is combinational, so one cycle suffices to capture.
                out_data_d  = mem_rdata;
                out_index_d = idx_q;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    // Leaving for DONE before incrementing keeps idx from wrapping.
                    if (at_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        cpu_stall = busy;
        out_valid = (state_q == SEND);
        out_last  = out_valid & at_last;
        done      = (state_q == DONE);
        if (busy) begin
            // Stores during the stall are squashed; the stalled instruction
            // re-executes after release and reissues them.
            mem_addr  = idx_q;
            mem_wdata = '0;
            mem_we    = 1'b0;
        end else begin
            mem_addr  = cpu_addr[ADDR_W+2:3];
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end
    end

    assign out_data  = out_data_q;
    assign out_index = out_index_q;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// tb/tb_dmem_dump_ctrl.sv - self-checking bench for dmem_dump_ctrl

module tb_dmem_dump_ctrl;

    localparam int N      = 64;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              dump_req;
    logic [N-1:0]      cpu_addr;
    logic [N-1:0]      cpu_wdata;
    logic              cpu_we;
    logic              cpu_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_wdata;
    logic              mem_we;
    logic [N-1:0]      mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] mem     [DEPTH];
    logic [N-1:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    dmem_dump_ctrl #(.N(N), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .dump_req  (dump_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Fill memory through the IDLE passthrough; ref_mem is the bench's own copy.
    task automatic load_mem(input bit random_data);
        logic [N-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            v = random_data ? {$urandom(), $urandom()} : N'(i * 'h11);
            cpu_addr  = N'(i * 8);
            cpu_wdata = v;
            cpu_we    = 1'b1;
            ref_mem[i] = v;
        end
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready held low 10 cycles at index 5;
    // 2: random ready. abort_at >= 0 asserts reset while that index is offered.
    task automatic run_dump(input int mode, input int abort_at, input int exp_done_n);
        logic [N-1:0] snap [DEPTH];
        logic [N-1:0] store_val;
        int  k, next_present, last_acc, done_cnt, hold, done_n;
        bit  fin, exp_busy, exp_done, present, rdy;
        for (int i = 0; i < DEPTH; i++) snap[i] = ref_mem[i];
        k = 0; next_present = 1; last_acc = -1; done_cnt = 0; hold = 0; done_n = -1;
        store_val = {$urandom(), $urandom()} | 64'h1;
        cpu_we    = 1'b0;
        out_ready = 1'b1;
        dump_req  = 1'b0;
        @(negedge clk);
        dump_req = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            fin      = (last_acc >= 0);
            exp_busy = !(fin && n >= last_acc + 2);
            exp_done = fin && (n == last_acc + 1);
            check("busy", busy, exp_busy);
            check("cpu_stall", cpu_stall, exp_busy);
            check("done", done, exp_done);
            if (exp_busy) begin
                check("mem_we_blocked", mem_we, 0);
                check("mem_addr_owned", mem_addr, (k > DEPTH - 1) ? DEPTH - 1 : k);
            end
            present = !fin && (n == next_present);
            check("out_valid", out_valid, present);
            if (present) begin
                check("out_index", out_index, k);
                check("out_data", out_data, snap[k]);
                check("out_last", out_last, k == DEPTH - 1);
                if (k == abort_at) begin
                    #2;
                    reset  = 1'b0;
                    cpu_we = 1'b0;
                    #1;
                    check("abort_busy", busy, 0);
                    check("abort_stall", cpu_stall, 0);
                    check("abort_valid", out_valid, 0);
                    check("abort_done", done, 0);
                    @(posedge clk);
                    @(negedge clk);
                    check("abort_busy_after", busy, 0);
                    check("abort_done_after", done, 0);
                    reset     = 1'b1;
                    out_ready = 1'b1;
                    return;
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       begin
                                 rdy = !(k == 5 && hold < 10);
                                 if (!rdy) hold++;
                             end
                    default: rdy = ($urandom_range(0, 3) != 0);
                endcase
                out_ready = rdy;
                if (rdy) begin
                    k++;
                    if (k == DEPTH) last_acc = n;
                    next_present = n + 2;
                end else begin
                    next_present = n + 1;
                end
            end else begin
                check("out_last_idle", out_last, 0);
                if (mode == 2) out_ready = $urandom_range(0, 1) != 0;
            end
            if (n == 0) begin
                cpu_addr  = '0;
                cpu_wdata = store_val;
                cpu_we    = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_n = n;
                check("mem0_unchanged", mem[0], snap[0]);
                cpu_we = 1'b0;
            end
            if (mode == 0 && n == 40) dump_req = 1'b0;
            if (mode == 0 && n == 41) dump_req = 1'b1;
            if (fin && n >= last_acc + 12) break;
        end
        cpu_we = 1'b0;
        check("words_sent", k, DEPTH);
        check("done_pulses", done_cnt, 1);
        if (exp_done_n >= 0) check("done_cycle", done_n, exp_done_n);
        out_ready = 1'b1;
    endtask

    initial begin
        logic [N-1:0] a, d;
        logic         w;
        reset     = 1'b0;
        dump_req  = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_mem_we", mem_we, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_trigger_at_release", busy, 0);
        end

        cpu_addr  = 64'h18;
        cpu_wdata = 64'hA5;
        cpu_we    = 1'b1;
        #1;
        check("pt_addr", mem_addr, 3);
        check("pt_wdata", mem_wdata, 64'hA5);
        check("pt_we", mem_we, 1);
        check("pt_stall", cpu_stall, 0);
        check("pt_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = {$urandom(), $urandom()};
            d = {$urandom(), $urandom()};
            w = 1'($urandom_range(0, 1));
            cpu_addr = a; cpu_wdata = d; cpu_we = w;
            #1;
            check("pt_rand_addr", mem_addr, (a / 8) % DEPTH);
            check("pt_rand_wdata", mem_wdata, d);
            check("pt_rand_we", mem_we, w);
        end

        load_mem(1'b0);
        run_dump(0, -1, 128);
        run_dump(1, -1, 138);
        load_mem(1'b1);
        run_dump(2, -1, -1);
        run_dump(0, 20, -1);
        run_dump(0, -1, 128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_dump_ctrl.md
Name: dmem_dump_ctrl

Overview:
- Sequencer and arbiter for the single-cycle ARM core's data memory port.
- In normal operation it passes the processor's data-memory requests straight through.
- On a dump request it stalls the processor, takes ownership of the memory, and reads out every word in ascending order over a valid/ready stream, for bench dumps and the debug host.
- When the dump finishes it releases the stall.

Parameters:
- N, 64, data word width in bits.
- ADDR_W, 6, word-address width; memory depth is 2**ADDR_W words.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- dump_req  in  1  dump request; a rising edge starts a dump.
- cpu_addr  in  N  processor byte address.
- cpu_wdata  in  N  processor store data.
- cpu_we  in  1  processor store enable.
- cpu_stall  out  1  holds the processor PC and register writes while high.
- mem_addr  out  ADDR_W  word address to data memory.
- mem_wdata  out  N  write data to data memory.
- mem_we  out  1  write enable to data memory.
- mem_rdata  in  N  data memory read data (combinational read).
- out_valid  out  1  dump word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  N  dump word.
- out_index  out  ADDR_W  word index of out_data.
- out_last  out  1  high together with out_valid on index 2**ADDR_W-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- States: IDLE, READ, SEND, DONE, held in a state register.
- Reset (reset=0, asynchronous):
  - state=IDLE, idx=0, out_data=0.
  - Edge-detect register = 1, so a dump_req already high at reset release does not trigger.
  - Every output is 0 except the IDLE passthrough values.
- Reset mid-dump: immediate return to IDLE, stall dropped, and no done pulse.
- IDLE:
  - mem_addr = cpu_addr[ADDR_W+2:3], mem_wdata = cpu_wdata, mem_we = cpu_we.
  - cpu_stall=0, out_valid=0.
- Trigger: dump_req high at an edge where it was low at the previous edge, while in IDLE → READ, idx=0.
  - A rising edge outside IDLE is ignored and not queued.
- Memory ownership:
  - In all states other than IDLE: cpu_stall=1, mem_we=0, mem_wdata=0, mem_addr=idx.
  - A CPU store in the stalled cycle is blocked; that instruction re-executes after release.
- READ: at the next edge, out_data ← mem_rdata and out_index ← idx, then → SEND. Lasts exactly 1 cycle.
- SEND:
  - out_valid=1; out_data and out_index stay stable until the handshake (out_valid & out_ready at an edge).
  - On handshake with idx == 2**ADDR_W-1 → DONE.
  - On handshake otherwise → idx ← idx+1, → READ.
  - With out_ready low, the block waits indefinitely.
- DONE: done=1 for one cycle, cpu_stall still 1; → IDLE at the next edge.
- Throughput: at most one word per 2 cycles. A full dump with out_ready tied high takes 2·2**ADDR_W+1 cycles from trigger to IDLE (129 for the defaults).
- out_last = (state==SEND) & (idx == 2**ADDR_W-1).
- idx never wraps, because the DONE exit precedes any increment past the maximum.
- busy = (state != IDLE).

Decomposition:
- Package dmem_dump_pkg holds:
  - the state enum type dump_state_t {IDLE, READ, SEND, DONE};
  - localparam function depth(ADDR_W).
- Sub-module rise_detect: one flop plus AND gate, with the async active-low reset value as a parameter (set to 1 here). It is reused for other debug strobes.
- Port muxing and the FSM live in dmem_dump_ctrl.

Test Plan:
- Passthrough:
  - Stimulus: IDLE, cpu_addr=0x18, cpu_wdata=0xA5, cpu_we=1.
  - Required: mem_addr=3, mem_wdata=0xA5, mem_we=1, cpu_stall=0, busy=0.
- Full dump:
  - Setup: preload mem[i]=i*0x11, pulse dump_req, out_ready tied 1.
  - Required: 64 words out, index 0..63, data i*0x11, out_last only on index 63, done pulse at cycle 129, cpu_stall low from cycle 130.
- Back-pressure:
  - Stimulus: out_ready=0 for 10 cycles at index 5.
  - Required: out_valid held, out_data=0x55 and out_index=5 stable throughout; index 6 appears 2 cycles after out_ready rises.
- Store blocking:
  - Stimulus: cpu_we=1, cpu_addr=0x0 held during a dump.
  - Required: mem_we=0 for all busy cycles, and mem[0] unchanged in the dump.
- Trigger rules:
  - dump_req high through reset release → no dump.
  - A second rising edge while busy → ignored; exactly one done pulse.
  - dump_req held high after done → no retrigger.
- Reset mid-dump:
  - Stimulus: reset=0 at index 20, asynchronously between clock edges.
  - Required: within the same cycle busy=0, cpu_stall=0, out_valid=0; no done pulse; the next trigger restarts at index 0.
